// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// Handshake: a requester raises rN_req with stable we/lock/addr/wdata and
// holds them until rN_gnt is seen high in the same cycle. The access happens
// in the gnt cycle. rN_rsp_valid pulses exactly one cycle later and carries
// rdata/err. There is no back-pressure on responses.
interface dmem_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          r0_req;
    logic          r0_we;
    logic          r0_lock;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r0_gnt;
    logic          r0_rsp_valid;
    logic [DW-1:0] r0_rsp_rdata;
    logic          r0_rsp_err;

    logic          r1_req;
    logic          r1_we;
    logic          r1_lock;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          r1_gnt;
    logic          r1_rsp_valid;
    logic [DW-1:0] r1_rsp_rdata;
    logic          r1_rsp_err;

    logic          mem_wr_en;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Requester/memory side (testbench or surrounding system)
    modport master (
        output r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
        input  r0_gnt, r0_rsp_valid, r0_rsp_rdata, r0_rsp_err,
        output r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
        input  r1_gnt, r1_rsp_valid, r1_rsp_rdata, r1_rsp_err,
        input  mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
        output mem_rdata
    );

    // Arbiter side
    modport slave (
        input  r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
        output r0_gnt, r0_rsp_valid, r0_rsp_rdata, r0_rsp_err,
        input  r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
        output r1_gnt, r1_rsp_valid, r1_rsp_rdata, r1_rsp_err,
        output mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with bounded lock in front of a single-ported
// word memory. One access per cycle; responses are registered one cycle later.
module dmem_arbiter #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int DEPTH    = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic       clk,
    input  logic       reset,
    dmem_arbiter_if.slave bus,
    output logic [1:0] state_dbg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] CNT_SAT = CW'(MAX_LOCK);
    localparam logic [CW-1:0] CNT_REL = CW'(MAX_LOCK - 1);

    state_t        state, state_nxt;
    logic          last, last_nxt;
    logic [CW-1:0] lock_cnt, lock_cnt_nxt;

    logic          gnt0, gnt1, any_gnt;
    logic          sel_we, sel_lock, in_range;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    assign state_dbg  = state;
    assign bus.r0_gnt = gnt0;
    assign bus.r1_gnt = gnt1;
    assign any_gnt    = gnt0 | gnt1;

    // Arbitration: owner-only while locked, round-robin on ties when idle.
    // No grant is issued while reset is held so nothing reaches memory.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            IDLE: begin
                if (bus.r0_req && bus.r1_req) begin
                    gnt0 = last;
                    gnt1 = !last;
                end else begin
                    gnt0 = bus.r0_req;
                    gnt1 = bus.r1_req;
                end
            end
            OWN0:    gnt0 = bus.r0_req;
            OWN1:    gnt1 = bus.r1_req;
            default: ;
        endcase
        if (reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    // Select the granted requester's fields and drive the memory port.
    always_comb begin
        sel_we    = gnt1 ? bus.r1_we    : bus.r0_we;
        sel_lock  = gnt1 ? bus.r1_lock  : bus.r0_lock;
        sel_addr  = gnt1 ? bus.r1_addr  : bus.r0_addr;
        sel_wdata = gnt1 ? bus.r1_wdata : bus.r0_wdata;
        in_range  = (sel_addr < AW'(DEPTH));
        bus.mem_wr_en = any_gnt && in_range && sel_we;
        bus.mem_rd_en = any_gnt && in_range && !sel_we;
        bus.mem_addr  = any_gnt ? sel_addr  : '0;
        bus.mem_wdata = any_gnt ? sel_wdata : '0;
    end

    // Next state: enter ownership on a locked grant, leave on an unlocked
    // owner grant or when the lock counter hits its limit.
    always_comb begin
        state_nxt    = state;
        last_nxt     = last;
        lock_cnt_nxt = lock_cnt;
        if (any_gnt) last_nxt = gnt1;
        case (state)
            IDLE: begin
                if (any_gnt && sel_lock) begin
                    state_nxt    = gnt1 ? OWN1 : OWN0;
                    lock_cnt_nxt = '0;
                end
            end
            OWN0, OWN1: begin
                if (lock_cnt != CNT_SAT) lock_cnt_nxt = lock_cnt + 1'b1;
                if (lock_cnt == CNT_REL) begin
                    // Forced release: the other requester wins the next tie.
                    state_nxt = IDLE;
                    last_nxt  = (state == OWN1);
                end else if (any_gnt && !sel_lock) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state, round-robin pointer and lock counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last     <= 1'b1;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    // Registered responses: one cycle after each grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.r0_rsp_valid <= 1'b0;
            bus.r0_rsp_err   <= 1'b0;
            bus.r0_rsp_rdata <= '0;
            bus.r1_rsp_valid <= 1'b0;
            bus.r1_rsp_err   <= 1'b0;
            bus.r1_rsp_rdata <= '0;
        end else begin
            bus.r0_rsp_valid <= gnt0;
            bus.r0_rsp_err   <= gnt0 && !in_range;
            bus.r0_rsp_rdata <= (gnt0 && in_range && !sel_we) ? bus.mem_rdata : '0;
            bus.r1_rsp_valid <= gnt1;
            bus.r1_rsp_err   <= gnt1 && !in_range;
            bus.r1_rsp_rdata <= (gnt1 && in_range && !sel_we) ? bus.mem_rdata : '0;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a response scoreboard and a memory model.
module tb_dmem_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;

    logic       clk;
    logic       reset;
    logic       mem_init;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    logic [DW:0] exp_q0[$];
    logic [DW:0] exp_q1[$];
    logic [DW:0] e0, e1;

    logic          g0, g1, wr, rd;
    logic [AW-1:0] ma;
    logic [1:0]    st;

    logic [DW-1:0] tb_mem [32];

    dmem_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    dmem_arbiter #(.DW(DW), .AW(AW), .DEPTH(32), .MAX_LOCK(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // memory model: combinational read, word 0 ignores writes
    always_comb begin
        bus.mem_rdata = (bus.mem_addr < 32) ? tb_mem[bus.mem_addr[4:0]] : '0;
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) tb_mem[i] <= (i == 0) ? 32'h0 : 32'h1000_0000 + i;
        end else if (bus.mem_wr_en && bus.mem_addr != 0) begin
            tb_mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
        end
    end

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // driver tasks
    task automatic drv0(input logic req, input logic we, input logic lock, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic err, input logic [DW-1:0] rdata);
        bus.r0_req = req; bus.r0_we = we; bus.r0_lock = lock;
        bus.r0_addr = addr; bus.r0_wdata = wdata; e0 = {err, rdata};
    endtask

    task automatic drv1(input logic req, input logic we, input logic lock, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic err, input logic [DW-1:0] rdata);
        bus.r1_req = req; bus.r1_we = we; bus.r1_lock = lock;
        bus.r1_addr = addr; bus.r1_wdata = wdata; e1 = {err, rdata};
    endtask

    // one clock: sample grant-cycle outputs, queue the expected responses
    task automatic cycle();
        @(negedge clk);
        g0 = bus.r0_gnt; g1 = bus.r1_gnt;
        wr = bus.mem_wr_en; rd = bus.mem_rd_en; ma = bus.mem_addr; st = state_dbg;
        if (g0) exp_q0.push_back(e0);
        if (g1) exp_q1.push_back(e1);
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset) check("one_gnt", {62'd0, bus.r0_gnt, bus.r1_gnt} == 64'd3, 64'd0);
        if (bus.r0_rsp_valid) begin
            if (exp_q0.size() == 0) begin
                check("r0_rsp_unexpected", 64'd1, 64'd0);
            end else begin
                check("r0_rsp", {31'd0, bus.r0_rsp_err, bus.r0_rsp_rdata}, {31'd0, exp_q0.pop_front()});
            end
        end
        if (bus.r1_rsp_valid) begin
            if (exp_q1.size() == 0) begin
                check("r1_rsp_unexpected", 64'd1, 64'd0);
            end else begin
                check("r1_rsp", {31'd0, bus.r1_rsp_err, bus.r1_rsp_rdata}, {31'd0, exp_q1.pop_front()});
            end
        end
    end

    initial begin
        int n;
        int r0_cnt;
        reset = 1'b1;
        mem_init = 1'b1;
        drv0(0, 0, 0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", state_dbg, 2'd0);
        check("rst_rsp", {bus.r0_rsp_valid, bus.r0_rsp_err, bus.r1_rsp_valid, bus.r1_rsp_err}, 4'd0);
        check("rst_rdata", {bus.r0_rsp_rdata, bus.r1_rsp_rdata}, 64'd0);
        check("rst_mem", {bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr}, 34'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        mem_init = 1'b0;

        // round-robin after reset: r0, r1, r0, r1
        drv0(1, 0, 0, 3, 0, 0, 32'h1000_0003);
        drv1(1, 0, 0, 4, 0, 0, 32'h1000_0004);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("rr_g0", g0, (i % 2) == 0);
            check("rr_g1", g1, (i % 2) == 1);
        end
        drv0(0, 0, 0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0, 0, 0);
        cycle();
        check("idle_mem", {wr, rd, ma}, 34'd0);

        // single write then read
        drv0(1, 1, 0, 5, 32'hDEAD_BEEF, 0, 0);
        cycle();
        check("wr5_gnt", {g0, wr, rd}, 3'b110);
        check("wr5_addr", ma, 5);
        drv0(1, 0, 0, 5, 0, 0, 32'hDEAD_BEEF);
        cycle();
        check("rd5_gnt", {g0, wr, rd}, 3'b101);
        // word 0 discards writes, arbiter still grants
        drv0(1, 1, 0, 0, 32'h55, 0, 0);
        cycle();
        check("wr0_gnt", {g0, wr}, 2'b11);
        drv0(1, 0, 0, 0, 0, 0, 0);
        cycle();
        // top in-range word
        drv0(1, 1, 0, 31, 32'h1234_5678, 0, 0);
        cycle();
        check("wr31_gnt", {g0, wr, rd}, 3'b110);
        check("wr31_addr", ma, 31);
        drv0(1, 0, 0, 31, 0, 0, 32'h1234_5678);
        cycle();
        drv0(0, 0, 0, 0, 0, 0, 0);

        // lock hold: last grant was r0, so r1 wins the tie and locks
        drv0(1, 0, 0, 10, 0, 0, 32'hA0A0_000A);
        drv1(1, 1, 1, 10, 32'hA0A0_000A, 0, 0);
        cycle();
        check("lk_first", {g0, g1}, 2'b01);
        for (int k = 1; k <= 3; k++) begin
            drv1(1, 1, (k < 3), 10 + k, 32'hA0A0_000A + k, 0, 0);
            cycle();
            check("lk_hold", {g0, g1}, 2'b01);
            check("lk_state", st, 2'd2);
        end
        drv1(0, 0, 0, 0, 0, 0, 0);
        cycle();
        check("lk_r0_after", {g0, g1, st}, 4'b1000);
        drv0(0, 0, 0, 0, 0, 0, 0);

        // forced release: make r1 last so r0 wins and locks
        drv1(1, 0, 0, 4, 0, 0, 32'h1000_0004);
        cycle();
        check("fr_pre", g1, 1'b1);
        drv0(1, 0, 1, 7, 0, 0, 32'h1000_0007);
        drv1(1, 0, 0, 8, 0, 0, 32'h1000_0008);
        n = 0;
        r0_cnt = 0;
        do begin
            cycle();
            n++;
            if (g0) r0_cnt++;
        end while (!g1 && n < 16);
        check("fr_r1_cycle", n, 10);
        check("fr_r0_grants", r0_cnt, 9);
        drv1(0, 0, 0, 0, 0, 0, 0);
        cycle();
        check("fr_relock", {g0, st}, 3'b100);
        drv0(1, 0, 0, 7, 0, 0, 32'h1000_0007);
        cycle();
        check("fr_unlock", {g0, st}, 3'b101);
        drv0(0, 0, 0, 0, 0, 0, 0);
        cycle();
        check("fr_idle", st, 2'd0);

        // out-of-range accesses
        drv1(1, 0, 0, 32, 0, 1, 0);
        cycle();
        check("oor_rd", {g1, rd, wr}, 3'b100);
        drv1(1, 1, 0, 32'hFFFF_FFFF, 32'h77, 1, 0);
        cycle();
        check("oor_wr", {g1, rd, wr}, 3'b100);
        drv1(0, 0, 0, 0, 0, 0, 0);
        cycle();

        // reset while r1 owns the memory
        drv1(1, 0, 1, 9, 0, 0, 32'h1000_0009);
        cycle();
        check("rl_lock", g1, 1'b1);
        drv1(0, 0, 0, 0, 0, 0, 0);
        drv0(1, 0, 0, 9, 0, 0, 32'h1000_0009);
        cycle();
        check("rl_stall", {g0, st}, 3'b010);
        reset = 1'b1;
        cycle();
        check("rl_rst_gnt", {g0, g1}, 2'b00);
        reset = 1'b0;
        check("rl_state", state_dbg, 2'd0);
        check("rl_rsp", {bus.r0_rsp_valid, bus.r0_rsp_err, bus.r1_rsp_valid, bus.r1_rsp_err}, 4'd0);
        check("rl_rdata", {bus.r0_rsp_rdata, bus.r1_rsp_rdata}, 64'd0);
        drv1(1, 0, 0, 9, 0, 0, 32'h1000_0009);
        cycle();
        check("rl_first", {g0, g1}, 2'b10);
        drv0(0, 0, 0, 0, 0, 0, 0);
        cycle();
        check("rl_second", {g0, g1}, 2'b01);
        drv1(0, 0, 0, 0, 0, 0, 0);
        repeat (3) cycle();

        check("q0_drained", exp_q0.size(), 0);
        check("q1_drained", exp_q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
